ccip_mmio_csr: RTL and testbench



---
 rtl/ccip_if_pkg.sv | 78 +++++++
 rtl/ccip_mmio_req_decode.sv | 69 ++++++
 rtl/ccip_mmio_csr.sv | 198 +++++++++++++++++++
 tb/tb_ccip_mmio_csr.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ccip_if_pkg.sv
// ccip_if_pkg: CCI-P types used by the MMIO CSR slave.
// Contents: MMIO header/bus structs for channel-0 receive and channel-2
// transmit, the MMIO length encoding, fixed DW addresses of the mandatory
// AFU registers, and the decode region type with a DW-select helper.
package ccip_if_pkg;

  typedef logic [15:0]  t_ccip_mmioAddr;
  typedef logic [8:0]   t_ccip_tid;
  typedef logic [511:0] t_ccip_clData;
  typedef logic [63:0]  t_ccip_mmioData;

  typedef enum logic [1:0] {
    eMMIO_LEN_4B  = 2'b00,
    eMMIO_LEN_8B  = 2'b01,
    eMMIO_LEN_64B = 2'b10
  } t_ccip_mmio_len;

  localparam t_ccip_mmioAddr CCIP_DFH_DW_ADDR      = 16'h0000;
  localparam t_ccip_mmioAddr CCIP_AFU_ID_L_DW_ADDR = 16'h0002;
  localparam t_ccip_mmioAddr CCIP_AFU_ID_H_DW_ADDR = 16'h0004;
  localparam t_ccip_mmioAddr CCIP_ERR_CNT_DW_ADDR  = 16'h0006;

  // Channel-0 memory response header; MMIO requests reuse the same bits.
  typedef struct packed {
    logic [1:0]  vc_used;
    logic        rsvd1;
    logic        hit_miss;
    logic [1:0]  rsvd0;
    logic [1:0]  cl_num;
    logic [3:0]  resp_type;
    logic [15:0] mdata;
  } t_ccip_c0_RspMemHdr;

  // Length is kept as raw bits so the illegal 2'b11 code stays observable.
  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_RspMemHdr hdr;
    t_ccip_clData       data;
    logic               rspValid;
    logic               mmioRdValid;
    logic               mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;

  typedef enum logic [2:0] {
    REG_NONE     = 3'd0,
    REG_DFH      = 3'd1,
    REG_AFU_ID_L = 3'd2,
    REG_AFU_ID_H = 3'd3,
    REG_ERR_CNT  = 3'd4,
    REG_CSR      = 3'd5,
    REG_STAT     = 3'd6
  } t_mmio_region;

  // 8B accesses return the whole word; 4B accesses return one DW right-aligned.
  function automatic t_ccip_mmioData mmio_dw_select(input t_ccip_mmioData full,
                                                    input logic is_8b,
                                                    input logic hi_dw);
    if (is_8b) return full;
    return {32'h0, hi_dw ? full[63:32] : full[31:0]};
  endfunction

endpackage

// File: rtl/ccip_mmio_req_decode.sv
// ccip_mmio_req_decode: combinational decode of one MMIO request.
// Ports:
//   rd_valid, wr_valid  request strobes (already gated by reset release)
//   address, length     request header fields (DW address, length code)
//   region              which register block the address hits
//   index               CSR / status word index within its window
//   hi_dw               upper-DW select for 4B accesses
//   is_8b               length is 8 bytes
//   malformed           request must be counted as an error
module ccip_mmio_req_decode
  import ccip_if_pkg::*;
#(
  parameter int          NUM_CSR   = 8,
  parameter int          NUM_STAT  = 4,
  parameter logic [15:0] CSR_BASE  = 16'h0020,
  parameter logic [15:0] STAT_BASE = 16'h0060
) (
  input  logic           rd_valid,
  input  logic           wr_valid,
  input  t_ccip_mmioAddr address,
  input  logic [1:0]     length,
  output t_mmio_region   region,
  output logic [4:0]     index,
  output logic           hi_dw,
  output logic           is_8b,
  output logic           malformed
);

  // Offsets are one bit wider so an address below the base wraps to a large
  // value and fails the window-size compare.
  logic [16:0] csr_off;
  logic [16:0] stat_off;
  logic        csr_hit;
  logic        stat_hit;

  assign csr_off  = {1'b0, address} - {1'b0, CSR_BASE};
  assign stat_off = {1'b0, address} - {1'b0, STAT_BASE};
  assign csr_hit  = (address >= CSR_BASE)  && (csr_off  < 17'(2 * NUM_CSR));
  assign stat_hit = (address >= STAT_BASE) && (stat_off < 17'(2 * NUM_STAT));

  assign hi_dw = address[0];
  assign is_8b = (length == eMMIO_LEN_8B);

  // Simultaneous read and write is malformed even though each alone may be fine.
  assign malformed = (rd_valid || wr_valid) &&
                     (length[1] || (is_8b && address[0]) || (rd_valid && wr_valid));

  // Fixed registers take priority over the parameterised windows.
  always_comb begin
    region = REG_NONE;
    index  = '0;
    if (address[15:1] == CCIP_DFH_DW_ADDR[15:1]) begin
      region = REG_DFH;
    end else if (address[15:1] == CCIP_AFU_ID_L_DW_ADDR[15:1]) begin
      region = REG_AFU_ID_L;
    end else if (address[15:1] == CCIP_AFU_ID_H_DW_ADDR[15:1]) begin
      region = REG_AFU_ID_H;
    end else if (address[15:1] == CCIP_ERR_CNT_DW_ADDR[15:1]) begin
      region = REG_ERR_CNT;
    end else if (csr_hit) begin
      region = REG_CSR;
      index  = csr_off[5:1];
    end else if (stat_hit) begin
      region = REG_STAT;
      index  = stat_off[5:1];
    end
  end

endmodule

// File: rtl/ccip_mmio_csr.sv
// ccip_mmio_csr: CCI-P MMIO CSR slave with fixed 2-cycle read latency.
// Ports:
//   pClk                   interface clock
//   pck_cp2af_softReset_n  asynchronous active-low reset
//   c0_rx                  host channel-0 bus (MMIO read/write requests)
//   c2_tx                  MMIO read response (tid, valid, data)
//   csr_q                  read-write CSR contents, CSR i at [64*i+63:64*i]
//   csr_wr_pulse           per-CSR strobe, high in the cycle csr_q updates
//   stat_in                AFU status words, sampled when a read is answered
//   err_cnt                saturating count of malformed requests
// Pipeline: decoded request registered in stage 1 (write commits at the end
// of stage 1); read data muxed from stage-1 registers and registered onto c2.
module ccip_mmio_csr
  import ccip_if_pkg::*;
#(
  parameter int           NUM_CSR   = 8,
  parameter int           NUM_STAT  = 4,
  parameter logic [15:0]  CSR_BASE  = 16'h0020,
  parameter logic [15:0]  STAT_BASE = 16'h0060,
  parameter logic [127:0] AFU_ID    = 128'h0,
  parameter logic [63:0]  DFH_VALUE = 64'h1000_0000_0000_0000,
  // A zero-status build still needs a legal port width.
  localparam int          STAT_W    = (NUM_STAT > 0) ? NUM_STAT * 64 : 64
) (
  input  logic                   pClk,
  input  logic                   pck_cp2af_softReset_n,
  input  t_if_ccip_c0_Rx         c0_rx,
  output t_if_ccip_c2_Tx         c2_tx,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_pulse,
  input  logic [STAT_W-1:0]      stat_in,
  output logic [15:0]            err_cnt
);

  logic rst_n;
  assign rst_n = pck_cp2af_softReset_n;

  // Reset release is synchronised: requests are accepted only once the
  // second stage has seen the deasserted reset.
  logic [1:0] rst_sync_reg;
  logic       accept;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) rst_sync_reg <= '0;
    else        rst_sync_reg <= {rst_sync_reg[0], 1'b1};
  end
  assign accept = rst_sync_reg[1];

  t_ccip_c0_ReqMmioHdr req_hdr;
  logic                rd_req;
  logic                wr_req;

  assign req_hdr = t_ccip_c0_ReqMmioHdr'(c0_rx.hdr);
  assign rd_req  = accept & c0_rx.mmioRdValid;
  assign wr_req  = accept & c0_rx.mmioWrValid;

  logic unused_ok;
  assign unused_ok = ^{req_hdr.rsvd, c0_rx.data[511:64], c0_rx.rspValid};

  t_mmio_region dec_region;
  logic [4:0]   dec_index;
  logic         dec_hi_dw;
  logic         dec_is_8b;
  logic         dec_malformed;

  ccip_mmio_req_decode #(
    .NUM_CSR   (NUM_CSR),
    .NUM_STAT  (NUM_STAT),
    .CSR_BASE  (CSR_BASE),
    .STAT_BASE (STAT_BASE)
  ) u_decode (
    .rd_valid  (rd_req),
    .wr_valid  (wr_req),
    .address   (req_hdr.address),
    .length    (req_hdr.length),
    .region    (dec_region),
    .index     (dec_index),
    .hi_dw     (dec_hi_dw),
    .is_8b     (dec_is_8b),
    .malformed (dec_malformed)
  );

  // Stage 1 registers.
  logic           s1_rd_reg;
  logic           s1_csr_wr_reg;
  logic           s1_bad_reg;
  t_ccip_tid      s1_tid_reg;
  t_mmio_region   s1_region_reg;
  logic [4:0]     s1_idx_reg;
  logic           s1_hi_reg;
  logic           s1_8b_reg;
  t_ccip_mmioData s1_wdata_reg;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      s1_rd_reg     <= 1'b0;
      s1_csr_wr_reg <= 1'b0;
      s1_bad_reg    <= 1'b0;
      s1_tid_reg    <= '0;
      s1_region_reg <= REG_NONE;
      s1_idx_reg    <= '0;
      s1_hi_reg     <= 1'b0;
      s1_8b_reg     <= 1'b0;
      s1_wdata_reg  <= '0;
    end else begin
      s1_rd_reg     <= rd_req;
      // Only well-formed CSR writes survive; everything else is dropped here.
      s1_csr_wr_reg <= wr_req && !dec_malformed && (dec_region == REG_CSR);
      s1_bad_reg    <= dec_malformed;
      s1_tid_reg    <= req_hdr.tid;
      s1_region_reg <= dec_region;
      s1_idx_reg    <= dec_index;
      s1_hi_reg     <= dec_hi_dw;
      s1_8b_reg     <= dec_is_8b;
      s1_wdata_reg  <= c0_rx.data[63:0];
    end
  end

  logic [15:0] err_cnt_reg;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (dec_malformed && (err_cnt_reg != 16'hFFFF)) begin
      err_cnt_reg <= err_cnt_reg + 16'd1;
    end
  end
  assign err_cnt = err_cnt_reg;

  // CSR bank: each CSR owns its storage and strobe.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CSR; gi++) begin : g_csr
      logic [63:0] q_reg;
      logic        pulse_reg;
      logic        hit;

      assign hit = s1_csr_wr_reg && (s1_idx_reg == 5'(gi));

      always_ff @(posedge pClk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg     <= '0;
          pulse_reg <= 1'b0;
        end else begin
          pulse_reg <= hit;
          if (hit) begin
            if (s1_8b_reg)      q_reg        <= s1_wdata_reg;
            else if (s1_hi_reg) q_reg[63:32] <= s1_wdata_reg[31:0];
            else                q_reg[31:0]  <= s1_wdata_reg[31:0];
          end
        end
      end

      assign csr_q[64*gi +: 64] = q_reg;
      assign csr_wr_pulse[gi]   = pulse_reg;
    end
  endgenerate

  // Stage-2 read mux; sees csr_q after any write committed one cycle earlier.
  t_ccip_mmioData rd_full;
  t_ccip_mmioData rd_data;

  always_comb begin
    rd_full = '0;
    case (s1_region_reg)
      REG_DFH:      rd_full = DFH_VALUE;
      REG_AFU_ID_L: rd_full = AFU_ID[63:0];
      REG_AFU_ID_H: rd_full = AFU_ID[127:64];
      REG_ERR_CNT:  rd_full = {48'h0, err_cnt_reg};
      REG_CSR: begin
        for (int i = 0; i < NUM_CSR; i++) begin
          if (s1_idx_reg == 5'(i)) rd_full = csr_q[64*i +: 64];
        end
      end
      REG_STAT: begin
        for (int i = 0; i < NUM_STAT; i++) begin
          if (s1_idx_reg == 5'(i)) rd_full = stat_in[64*i +: 64];
        end
      end
      default: rd_full = '0;
    endcase
    rd_data = s1_bad_reg ? '0 : mmio_dw_select(rd_full, s1_8b_reg, s1_hi_reg);
  end

  t_if_ccip_c2_Tx c2_tx_reg;

  always_ff @(posedge pClk or negedge rst_n) begin
    if (!rst_n) begin
      c2_tx_reg <= '0;
    end else begin
      c2_tx_reg.mmioRdValid <= s1_rd_reg;
      c2_tx_reg.hdr.tid     <= s1_rd_reg ? s1_tid_reg : '0;
      c2_tx_reg.data        <= s1_rd_reg ? rd_data : '0;
    end
  end
  assign c2_tx = c2_tx_reg;

endmodule

// File: tb/tb_ccip_mmio_csr.sv
module tb_ccip_mmio_csr;
  import ccip_if_pkg::*;

  localparam int           NUM_CSR  = 8;
  localparam int           NUM_STAT = 4;
  localparam logic [127:0] AFU_ID_P = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [63:0]  DFH_P    = 64'h1000_0000_0000_0000;
  localparam logic [1:0]   L4       = 2'b00;
  localparam logic [1:0]   L8       = 2'b01;

  logic                      pClk = 1'b0;
  logic                      rst_n;
  t_if_ccip_c0_Rx            c0_rx;
  t_if_ccip_c2_Tx            c2_tx;
  logic [NUM_CSR*64-1:0]     csr_q;
  logic [NUM_CSR-1:0]        csr_wr_pulse;
  logic [NUM_STAT*64-1:0]    stat_in;
  logic [15:0]               err_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb_q[$];

  ccip_mmio_csr #(
    .NUM_CSR   (NUM_CSR),
    .NUM_STAT  (NUM_STAT),
    .CSR_BASE  (16'h0020),
    .STAT_BASE (16'h0060),
    .AFU_ID    (AFU_ID_P),
    .DFH_VALUE (DFH_P)
  ) dut (
    .pClk                  (pClk),
    .pck_cp2af_softReset_n (rst_n),
    .c0_rx                 (c0_rx),
    .c2_tx                 (c2_tx),
    .csr_q                 (csr_q),
    .csr_wr_pulse          (csr_wr_pulse),
    .stat_in               (stat_in),
    .err_cnt               (err_cnt)
  );

  always #5 pClk = ~pClk;
  always @(posedge pClk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response monitor: every c2 beat must match the oldest expected read,
  // including the cycle it appears in.
  always @(negedge pClk) begin
    exp_t e;
    if (c2_tx.mmioRdValid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL unexpected_rsp tid=%h observed_valid=1 expected_valid=0", c2_tx.hdr.tid);
      end else begin
        e = sb_q.pop_front();
        $display("rsp cyc=%0d tid=%h data=%h", cyc, c2_tx.hdr.tid, c2_tx.data);
        check("rsp_tid", 64'(c2_tx.hdr.tid), 64'(e.tid));
        check("rsp_data", c2_tx.data, e.data);
        check("rsp_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pClk);
    #1;
  endtask

  task automatic send(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [1:0] len, input logic [8:0] tid, input logic [63:0] wdata);
    t_ccip_c0_ReqMmioHdr h;
    h = '0;
    h.address = addr;
    h.length  = len;
    h.tid     = tid;
    c0_rx = '0;
    c0_rx.hdr = t_ccip_c0_RspMemHdr'(h);
    c0_rx.data[63:0] = wdata;
    c0_rx.mmioRdValid = rd;
    c0_rx.mmioWrValid = wr;
    $display("req cyc=%0d rd=%0b wr=%0b addr=%h len=%0d tid=%h wdata=%h", cyc, rd, wr, addr, len, tid, wdata);
    @(posedge pClk);
    #1;
    c0_rx.mmioRdValid = 1'b0;
    c0_rx.mmioWrValid = 1'b0;
  endtask

  task automatic mmio_rd(input logic [15:0] addr, input logic [1:0] len,
                         input logic [8:0] tid, input logic [63:0] exp);
    sb_q.push_back('{tid: tid, data: exp, due: cyc + 2});
    send(1'b1, 1'b0, addr, len, tid, 64'h0);
  endtask

  task automatic mmio_wr(input logic [15:0] addr, input logic [1:0] len, input logic [63:0] data);
    send(1'b0, 1'b1, addr, len, 9'h0, data);
  endtask

  initial begin
    c0_rx   = '0;
    stat_in = {64'h4444_4444_DDDD_DDDD, 64'h3333_3333_CCCC_CCCC,
               64'h2222_2222_BBBB_BBBB, 64'h1111_1111_AAAA_AAAA};
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick(3);
    check("rst_c2_valid", 64'(c2_tx.mmioRdValid), 64'h0);
    check("rst_c2_tid", 64'(c2_tx.hdr.tid), 64'h0);
    check("rst_c2_data", c2_tx.data, 64'h0);
    check("rst_csr_q_lo", csr_q[63:0], 64'h0);
    check("rst_csr_q_hi", csr_q[511:448], 64'h0);
    check("rst_pulse", 64'(csr_wr_pulse), 64'h0);
    check("rst_err_cnt", 64'(err_cnt), 64'h0);
    rst_n = 1'b1;
    tick(3);

    // 8B write then 8B read of CSR0.
    mmio_wr(16'h0020, L8, 64'hDEAD_BEEF_0123_4567);
    tick(1);
    check("wr0_pulse", 64'(csr_wr_pulse), 64'h01);
    check("wr0_csr_q", csr_q[63:0], 64'hDEAD_BEEF_0123_4567);
    tick(1);
    check("wr0_pulse_end", 64'(csr_wr_pulse), 64'h0);
    mmio_rd(16'h0020, L8, 9'h055, 64'hDEAD_BEEF_0123_4567);

    // 4B half writes of CSR1.
    mmio_wr(16'h0023, L4, 64'h0000_0000_AAAA_5555);
    tick(1);
    check("wr1_pulse", 64'(csr_wr_pulse), 64'h02);
    check("wr1_csr_q", csr_q[127:64], 64'hAAAA_5555_0000_0000);
    mmio_rd(16'h0023, L4, 9'h056, 64'h0000_0000_AAAA_5555);
    mmio_wr(16'h0022, L4, 64'hFFFF_FFFF_1234_5678);
    tick(1);
    check("wr1_lo_csr_q", csr_q[127:64], 64'hAAAA_5555_1234_5678);
    mmio_rd(16'h0022, L8, 9'h057, 64'hAAAA_5555_1234_5678);

    // Back-to-back fixed-map and unmapped reads.
    mmio_rd(16'h0000, L8, 9'h001, DFH_P);
    mmio_rd(16'h0002, L8, 9'h002, AFU_ID_P[63:0]);
    mmio_rd(16'h0004, L8, 9'h003, AFU_ID_P[127:64]);
    mmio_rd(16'h0100, L8, 9'h004, 64'h0);

    // Write immediately followed by read of the same CSR, and window edges.
    mmio_wr(16'h0024, L8, 64'h0F0F_0F0F_F0F0_F0F0);
    mmio_rd(16'h0024, L8, 9'h010, 64'h0F0F_0F0F_F0F0_F0F0);
    mmio_wr(16'h002E, L8, 64'h7777_0000_0000_7777);
    tick(1);
    check("wr7_pulse", 64'(csr_wr_pulse), 64'h80);
    mmio_wr(16'h0030, L8, 64'h1234_1234_1234_1234);
    tick(1);
    check("wr_past_end_pulse", 64'(csr_wr_pulse), 64'h0);
    mmio_rd(16'h0030, L8, 9'h011, 64'h0);
    mmio_rd(16'h002E, L8, 9'h012, 64'h7777_0000_0000_7777);

    // Status window reads; write to status is ignored.
    mmio_rd(16'h0062, L8, 9'h020, 64'h2222_2222_BBBB_BBBB);
    mmio_rd(16'h0065, L4, 9'h021, 64'h0000_0000_3333_3333);
    mmio_wr(16'h0060, L8, 64'h5555_5555_5555_5555);
    tick(1);
    check("wr_stat_pulse", 64'(csr_wr_pulse), 64'h0);

    // Malformed: misaligned 8B read and 64B write.
    mmio_rd(16'h0021, L8, 9'h0AA, 64'h0);
    mmio_wr(16'h0020, 2'b10, 64'h1111_2222_3333_4444);
    tick(1);
    check("bad_wr_pulse", 64'(csr_wr_pulse), 64'h0);
    tick(2);
    check("bad_err_cnt", 64'(err_cnt), 64'd2);
    check("bad_csr_q", csr_q[63:0], 64'hDEAD_BEEF_0123_4567);

    // Same-cycle read and write.
    sb_q.push_back('{tid: 9'h0BB, data: 64'h0, due: cyc + 2});
    send(1'b1, 1'b1, 16'h0020, L8, 9'h0BB, 64'h9999_9999_9999_9999);
    tick(1);
    check("rdwr_pulse", 64'(csr_wr_pulse), 64'h0);
    tick(2);
    check("rdwr_err_cnt", 64'(err_cnt), 64'd3);
    check("rdwr_csr_q", csr_q[63:0], 64'hDEAD_BEEF_0123_4567);
    mmio_rd(16'h0006, L8, 9'h0CC, 64'd3);
    tick(4);

    // Reset one cycle after a read request: no response may appear.
    send(1'b1, 1'b0, 16'h0000, L8, 9'h1FF, 64'h0);
    rst_n = 1'b0;
    tick(3);
    check("mid_rst_c2_valid", 64'(c2_tx.mmioRdValid), 64'h0);
    check("mid_rst_c2_data", c2_tx.data, 64'h0);
    check("mid_rst_csr_q", csr_q[63:0], 64'h0);
    check("mid_rst_err_cnt", 64'(err_cnt), 64'h0);
    rst_n = 1'b1;
    tick(3);
    mmio_rd(16'h0020, L8, 9'h031, 64'h0);
    mmio_rd(16'h0000, L8, 9'h032, DFH_P);
    tick(5);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
